// File: rtl/bcd_decode_scheduler_pkg.sv
// Shared types and defaults for the BCD decode scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package bcd_decode_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_WAIT_DEC = 3'd3,
        ST_CAPTURE  = 3'd4
    } state_e;

    localparam int DEC_LATENCY_DEF = 32;
    localparam int MAX_VALUE_DEF   = 9999;
    localparam int STARTUP_CYCLES  = 2;

    function automatic int rr_index(
        input int base,
        input int offset,
        input int n
    );
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/bcd_decode_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first active request at or
// after ptr, wrapping around the requester ring.
module rr_arbiter
    import bcd_decode_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    int            idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = rr_index(int'(ptr), k, NUM_REQ);
            idx_w = ID_W'(idx);
            if (!grant_valid && req[idx_w]) begin
                grant_id    = idx_w;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_decode_scheduler.sv
// Shares one binary-to-BCD decoder among NUM_REQ requesters,
// serialising requests round-robin and saturating at MAX_VALUE.
module bcd_decode_scheduler
    import bcd_decode_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int N           = 16,
    parameter int M           = 16,
    parameter int DEC_LATENCY = DEC_LATENCY_DEF,
    parameter int MAX_VALUE   = MAX_VALUE_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*N-1:0]       bin_in,
    output logic [NUM_REQ-1:0]         ack,
    output logic [M-1:0]               res_bcd,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                       res_valid,
    output logic                       res_ovf,
    output logic                       dec_decode,
    output logic [N-1:0]               dec_bin,
    input  logic [M-1:0]               dec_bcd,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TW   = $clog2(DEC_LATENCY + 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                ovf_q, ovf_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [M-1:0]        res_bcd_q, res_bcd_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic                res_valid_q, res_valid_d;
    logic                res_ovf_q, res_ovf_d;
    logic                dec_decode_q, dec_decode_d;
    logic [N-1:0]        dec_bin_q, dec_bin_d;
    logic                busy_q, busy_d;

    logic [ID_W-1:0]     grant_id;
    logic                grant_valid;
    logic [N-1:0]        slice;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (req),
        .ptr         (ptr_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        id_d        = id_q;
        ovf_d       = ovf_q;
        ack_d       = '0;
        res_bcd_d   = res_bcd_q;
        res_id_d    = res_id_q;
        res_valid_d = 1'b0;
        res_ovf_d   = res_ovf_q;
        dec_bin_d   = dec_bin_q;
        slice       = bin_in[int'(grant_id)*N +: N];

        unique case (state_q)
            ST_STARTUP: begin
                dec_bin_d = '0;
                if (timer_q == TW'(STARTUP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_LAUNCH;
                    id_d    = grant_id;
                    ptr_d   = ID_W'(rr_index(int'(grant_id), 1, NUM_REQ));
                    if (slice > N'(MAX_VALUE)) begin
                        dec_bin_d = N'(MAX_VALUE);
                        ovf_d     = 1'b1;
                    end else begin
                        dec_bin_d = slice;
                        ovf_d     = 1'b0;
                    end
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT_DEC;
            end
            ST_WAIT_DEC: begin
                // result registers load on entry so ack lands in CAPTURE
                if (timer_q == TW'(DEC_LATENCY - 1)) begin
                    state_d       = ST_CAPTURE;
                    res_bcd_d     = dec_bcd;
                    res_id_d      = id_q;
                    res_ovf_d     = ovf_q;
                    res_valid_d   = 1'b1;
                    ack_d[id_q]   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase

        dec_decode_d = (state_d == ST_LAUNCH);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_STARTUP;
            ptr_q        <= '0;
            timer_q      <= '0;
            id_q         <= '0;
            ovf_q        <= 1'b0;
            ack_q        <= '0;
            res_bcd_q    <= '0;
            res_id_q     <= '0;
            res_valid_q  <= 1'b0;
            res_ovf_q    <= 1'b0;
            dec_decode_q <= 1'b0;
            dec_bin_q    <= '0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            id_q         <= id_d;
            ovf_q        <= ovf_d;
            ack_q        <= ack_d;
            res_bcd_q    <= res_bcd_d;
            res_id_q     <= res_id_d;
            res_valid_q  <= res_valid_d;
            res_ovf_q    <= res_ovf_d;
            dec_decode_q <= dec_decode_d;
            dec_bin_q    <= dec_bin_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign res_bcd    = res_bcd_q;
    assign res_id     = res_id_q;
    assign res_valid  = res_valid_q;
    assign res_ovf    = res_ovf_q;
    assign dec_decode = dec_decode_q;
    assign dec_bin    = dec_bin_q;
    assign busy       = busy_q;

endmodule
